// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: reset-default
// period/high calculations, channel-index width and channel state encoding.
package clk_div_pkg;

  typedef enum logic {
    CH_DIS = 1'b0,
    CH_RUN = 1'b1
  } ch_state_e;

  function automatic int ch_width(input int unsigned n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int unsigned def_period(input int unsigned sys_clk, input int unsigned clk_out);
    return sys_clk / clk_out;
  endfunction

  function automatic int unsigned def_high(input int unsigned period);
    return period / 2;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, live and shadow P/H, pending flag,
// DISABLED/RUN state and registered Clk_out/Tick.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned       DIV_W = 32,
  parameter logic [DIV_W-1:0]  DEF_P = '0,
  parameter logic [DIV_W-1:0]  DEF_H = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [DIV_W-1:0] wr_high,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  ch_state_e        state;
  logic [DIV_W-1:0] cnt, p, h, sp, sh;
  logic [DIV_W-1:0] cnt_inc, h_nxt;
  logic             wrap;

  assign cnt_inc = cnt + 1'b1;
  assign wrap    = (cnt == p - 1'b1);
  assign h_nxt   = pending ? sh : h;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CH_DIS;
      cnt     <= '0;
      p       <= DEF_P;
      h       <= DEF_H;
      sp      <= '0;
      sh      <= '0;
      pending <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      case (state)
        CH_DIS: begin
          if (wr) begin
            p <= wr_div;
            h <= wr_high;
          end
          if (en) begin
            state   <= CH_RUN;
            cnt     <= '0;
            clk_out <= wr ? (wr_high != '0) : (h != '0);
            tick    <= 1'b1;
          end
        end
        CH_RUN: begin
          if (!en) begin
            // Disabling flushes any pending write straight into P/H.
            state   <= CH_DIS;
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            pending <= 1'b0;
            if (pending) begin
              p <= sp;
              h <= sh;
            end
            if (wr) begin
              p <= wr_div;
              h <= wr_high;
            end
          end else begin
            if (wrap) begin
              cnt     <= '0;
              tick    <= 1'b1;
              clk_out <= (h_nxt != '0);
              if (pending) begin
                p       <= sp;
                h       <= sh;
                pending <= 1'b0;
              end
            end else begin
              cnt     <= cnt_inc;
              tick    <= 1'b0;
              clk_out <= (cnt_inc < h);
            end
            // Placed after the wrap handling so a write landing on a wrap
            // edge stays pending until the following wrap.
            if (wr) begin
              sp      <= wr_div;
              sh      <= wr_high;
              pending <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel runtime-programmable clock divider: shared load port decode,
// ready/err handling, and an array of independent channels.
module prog_clk_divider
  import clk_div_pkg::*;
#(
  parameter int unsigned SYS_CLK  = 50000000,
  parameter int unsigned CLK_OUT  = 1,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DIV_W    = 32,
  parameter int          CH_W     = ch_width(CHANNELS)
) (
  input  logic                Clk_in,
  input  logic                Rst_n,
  input  logic [CHANNELS-1:0] En,
  input  logic                Load_valid,
  output logic                Load_ready,
  input  logic [CH_W-1:0]     Load_chan,
  input  logic [DIV_W-1:0]    Load_div,
  input  logic [DIV_W-1:0]    Load_high,
  output logic                Load_err,
  output logic [CHANNELS-1:0] Clk_out,
  output logic [CHANNELS-1:0] Tick
);

  localparam logic [DIV_W-1:0] DEF_P = DIV_W'(def_period(SYS_CLK, CLK_OUT));
  localparam logic [DIV_W-1:0] DEF_H = DIV_W'(def_high(def_period(SYS_CLK, CLK_OUT)));

  logic [CHANNELS-1:0] pending, wr;
  logic                pend_sel, chan_ok, bad, accept;

  assign chan_ok    = ({1'b0, Load_chan} < (CH_W+1)'(CHANNELS));
  assign bad        = (Load_div < DIV_W'(2)) || !chan_ok;
  assign Load_ready = ~pend_sel;
  assign accept     = Load_valid & Load_ready;

  // Out-of-range channels match no entry, so they never hold off ready.
  always_comb begin
    pend_sel = 1'b0;
    for (int i = 0; i < int'(CHANNELS); i++)
      if (Load_chan == CH_W'(i)) pend_sel = pending[i];
  end

  always_comb begin
    wr = '0;
    for (int i = 0; i < int'(CHANNELS); i++)
      if (Load_chan == CH_W'(i)) wr[i] = accept & ~bad;
  end

  always_ff @(posedge Clk_in or negedge Rst_n) begin
    if (!Rst_n) Load_err <= 1'b0;
    else        Load_err <= accept & bad;
  end

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    clk_div_chan #(
      .DIV_W (DIV_W),
      .DEF_P (DEF_P),
      .DEF_H (DEF_H)
    ) u_chan (
      .clk     (Clk_in),
      .rst_n   (Rst_n),
      .en      (En[i]),
      .wr      (wr[i]),
      .wr_div  (Load_div),
      .wr_high (Load_high),
      .pending (pending[i]),
      .clk_out (Clk_out[i]),
      .tick    (Tick[i])
    );
  end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Bench for prog_clk_divider: expected Clk_out/Tick waveforms are queued as
// stimulus is driven and compared by a monitor after every rising edge.
module tb_prog_clk_divider;
  localparam int CH = 3;
  localparam int DW = 8;

  logic          Clk_in = 1'b0;
  logic          Rst_n = 1'b0;
  logic [CH-1:0] En = '0;
  logic          Load_valid = 1'b0;
  logic          Load_ready;
  logic [1:0]    Load_chan = '0;
  logic [DW-1:0] Load_div = '0;
  logic [DW-1:0] Load_high = '0;
  logic          Load_err;
  logic [CH-1:0] Clk_out, Tick;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [CH-1:0] clk;
    logic [CH-1:0] tick;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  prog_clk_divider #(
    .SYS_CLK (8),
    .CLK_OUT (2),
    .CHANNELS(CH),
    .DIV_W   (DW)
  ) dut (
    .Clk_in    (Clk_in),
    .Rst_n     (Rst_n),
    .En        (En),
    .Load_valid(Load_valid),
    .Load_ready(Load_ready),
    .Load_chan (Load_chan),
    .Load_div  (Load_div),
    .Load_high (Load_high),
    .Load_err  (Load_err),
    .Clk_out   (Clk_out),
    .Tick      (Tick)
  );

  always #5 Clk_in = ~Clk_in;

  // Scoreboard consumer: one queued entry per rising edge while entries exist.
  always begin
    @(posedge Clk_in);
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (Clk_out !== mon_e.clk || Tick !== mon_e.tick) begin
        errors++;
        $display("FAIL wave t=%0t Clk_out=%b Tick=%b expected Clk_out=%b Tick=%b",
                 $time, Clk_out, Tick, mon_e.clk, mon_e.tick);
      end
    end
  end

  // n cycles of a P/H waveform on channel ch, starting at the period start.
  task automatic push_wave(input int ch, input int p, input int h, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.clk = '0;
      e.tick = '0;
      e.clk[ch]  = ((i % p) < h);
      e.tick[ch] = ((i % p) == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_idle(input int n);
    exp_t e;
    e.clk = '0;
    e.tick = '0;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic drive_wr(input logic [1:0] ch, input int d, input int h);
    Load_valid = 1'b1;
    Load_chan  = ch;
    Load_div   = DW'(d);
    Load_high  = DW'(h);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clk_in);
    checks++;
    if (Clk_out !== '0 || Tick !== '0 || Load_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs Clk_out=%b Tick=%b Load_err=%b expected 000 000 0", Clk_out, Tick, Load_err);
    end
    Rst_n = 1'b1;
    checks++;
    if (Load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready Load_ready=%b expected 1", Load_ready);
    end
    En = 3'b001;
    push_wave(0, 4, 2, 12);
    repeat (12) @(negedge Clk_in);
  endtask

  task automatic test_reload_run();
    push_wave(0, 4, 2, 4);
    push_wave(0, 6, 1, 12);
    repeat (2) @(negedge Clk_in);
    checks++;
    if (Load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reload_ready_pre Load_ready=%b expected 1", Load_ready);
    end
    drive_wr(2'd0, 6, 1);
    @(negedge Clk_in);
    Load_valid = 1'b0;
    checks++;
    if (Load_ready !== 1'b0 || Load_err !== 1'b0) begin
      errors++;
      $display("FAIL reload_pending Load_ready=%b Load_err=%b expected 0 0", Load_ready, Load_err);
    end
    repeat (13) @(negedge Clk_in);
  endtask

  task automatic test_back_to_back();
    push_wave(0, 6, 1, 6);
    push_wave(0, 3, 2, 3);
    push_wave(0, 5, 5, 10);
    repeat (2) @(negedge Clk_in);
    drive_wr(2'd0, 3, 2);
    @(negedge Clk_in);
    drive_wr(2'd0, 5, 5);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (Load_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_held[%0d] Load_ready=%b expected 0", i, Load_ready);
      end
      @(negedge Clk_in);
    end
    checks++;
    if (Load_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_after_wrap Load_ready=%b expected 1", Load_ready);
    end
    @(negedge Clk_in);
    Load_valid = 1'b0;
    repeat (11) @(negedge Clk_in);
  endtask

  task automatic test_reject();
    push_wave(0, 5, 5, 10);
    drive_wr(2'd0, 1, 0);
    @(negedge Clk_in);
    checks++;
    if (Load_err !== 1'b1) begin
      errors++;
      $display("FAIL rej_div_err Load_err=%b expected 1", Load_err);
    end
    Load_valid = 1'b0;
    @(negedge Clk_in);
    checks++;
    if (Load_err !== 1'b0 || Load_ready !== 1'b1) begin
      errors++;
      $display("FAIL rej_div_after Load_err=%b Load_ready=%b expected 0 1", Load_err, Load_ready);
    end
    drive_wr(2'd3, 4, 2);
    @(negedge Clk_in);
    checks++;
    if (Load_err !== 1'b1) begin
      errors++;
      $display("FAIL rej_chan_err Load_err=%b expected 1", Load_err);
    end
    Load_valid = 1'b0;
    Load_chan  = 2'd0;
    @(negedge Clk_in);
    checks++;
    if (Load_err !== 1'b0 || Load_ready !== 1'b1) begin
      errors++;
      $display("FAIL rej_chan_after Load_err=%b Load_ready=%b expected 0 1", Load_err, Load_ready);
    end
    repeat (6) @(negedge Clk_in);
  endtask

  task automatic test_duty_disable();
    // Write lands on a wrap edge: one more P=5 period before H=0 takes over.
    push_wave(0, 5, 5, 5);
    push_wave(0, 4, 0, 8);
    drive_wr(2'd0, 4, 0);
    @(negedge Clk_in);
    Load_valid = 1'b0;
    repeat (12) @(negedge Clk_in);
    push_wave(0, 4, 0, 3);
    repeat (2) @(negedge Clk_in);
    drive_wr(2'd0, 2, 1);
    @(negedge Clk_in);
    Load_valid = 1'b0;
    checks++;
    if (Load_ready !== 1'b0) begin
      errors++;
      $display("FAIL dis_pending Load_ready=%b expected 0", Load_ready);
    end
    En = 3'b000;
    push_idle(3);
    repeat (3) @(negedge Clk_in);
    checks++;
    if (Load_ready !== 1'b1) begin
      errors++;
      $display("FAIL dis_flushed Load_ready=%b expected 1", Load_ready);
    end
    En = 3'b001;
    push_wave(0, 2, 1, 6);
    repeat (6) @(negedge Clk_in);
  endtask

  task automatic test_async_reset();
    push_wave(0, 2, 1, 1);
    drive_wr(2'd0, 7, 3);
    @(negedge Clk_in);
    Load_valid = 1'b0;
    checks++;
    if (Load_ready !== 1'b0) begin
      errors++;
      $display("FAIL arst_pending Load_ready=%b expected 0", Load_ready);
    end
    #1 Rst_n = 1'b0;
    #1;
    checks++;
    if (Clk_out !== '0 || Tick !== '0 || Load_ready !== 1'b1) begin
      errors++;
      $display("FAIL arst_immediate Clk_out=%b Tick=%b Load_ready=%b expected 000 000 1", Clk_out, Tick, Load_ready);
    end
    @(negedge Clk_in);
    checks++;
    if (Clk_out !== '0 || Tick !== '0) begin
      errors++;
      $display("FAIL arst_held Clk_out=%b Tick=%b expected 000 000", Clk_out, Tick);
    end
    Rst_n = 1'b1;
    push_wave(0, 4, 2, 8);
    repeat (8) @(negedge Clk_in);
  endtask

  initial begin
    test_reset();
    test_reload_run();
    test_back_to_back();
    test_reject();
    test_duty_disable();
    test_async_reset();
    @(negedge Clk_in);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
